// File: rtl/cv32e40p_x_acc_resp.sv
// Accelerator-side x-interface responder: decodes, queues in order, and executes
// offloaded compute ops (fixed-latency ALU) and single-beat memory ops.
package cv32e40p_x_acc_pkg;
    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_req_type_e;
endpackage

module cv32e40p_x_acc_resp
    import cv32e40p_x_acc_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned EXEC_LAT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 x_valid_i,
    output logic                 x_ready_o,
    input  logic [31:0]          x_instr_i,
    input  logic [1:0][31:0]     x_rs_i,
    input  logic [1:0]           x_rs_valid_i,
    input  logic                 x_rd_clean_i,
    output logic                 x_accept_o,
    output logic                 x_is_mem_op_o,
    output logic                 x_writeback_o,
    output logic                 x_rvalid_o,
    input  logic                 x_rready_i,
    output logic [4:0]           x_rwaddr_o,
    output logic [31:0]          x_rdata_o,
    output logic                 xmem_valid_o,
    input  logic                 xmem_ready_i,
    output mem_req_type_e        xmem_req_type_o,
    output logic [31:0]          xmem_addr_o,
    output logic [31:0]          xmem_wdata_o,
    output logic                 xmem_endoftransaction_o,
    input  logic                 xmem_rvalid_i,
    output logic                 xmem_rready_o
);

    localparam logic [6:0] OPC_COMP = 7'b0001011;
    localparam logic [6:0] OPC_MEM  = 7'b0101011;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int LAT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT + 1) : 1;

    typedef struct packed {
        logic        is_mem;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_RESP,
        S_MREQ,
        S_MRESP
    } state_e;

    function automatic logic [31:0] alu_op(input logic [1:0] op,
                                           input logic signed [31:0] a,
                                           input logic signed [31:0] b);
        logic signed [31:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a ^ b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        dec_comp;
    logic        dec_mem;
    logic        full;
    logic        push;
    logic        pop;
    logic        res_load;
    logic        mreq_load;
    logic        unused_instr;
    entry_t      push_entry;
    entry_t      head;
    entry_t      q_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    state_e      state_q;
    state_e      state_d;
    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    assign opcode       = x_instr_i[6:0];
    assign rd           = x_instr_i[11:7];
    assign funct3       = x_instr_i[14:12];
    assign unused_instr = ^x_instr_i[31:15];

    // Decode is purely combinational so accept/ready answer in the request cycle
    assign dec_comp      = (opcode == OPC_COMP) && !funct3[2];
    assign dec_mem       = (opcode == OPC_MEM) && (funct3[2:1] == 2'b00);
    assign x_accept_o    = dec_comp || dec_mem;
    assign x_is_mem_op_o = dec_mem;
    assign x_writeback_o = dec_comp && (rd != 5'd0);

    assign full      = (occ_q == OCC_W'(DEPTH));
    assign x_ready_o = !x_accept_o ||
                       (!full && (x_rs_valid_i == 2'b11) && (x_rd_clean_i || !x_writeback_o));
    assign push      = x_valid_i && x_ready_o && x_accept_o;

    assign push_entry = '{is_mem: dec_mem, op: funct3[1:0], rd: rd,
                          rs1: x_rs_i[0], rs2: x_rs_i[1]};
    assign head       = q_mem[rd_ptr_q];

    // Queue payload carries no reset; only pointers/occupancy qualify it
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_mem[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Head entry stays in the queue until it retires, so it is read in place
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        res_load  = 1'b0;
        mreq_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (occ_q != '0) begin
                    if (head.is_mem) begin
                        state_d   = S_MREQ;
                        mreq_load = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                        cnt_d   = LAT_W'(EXEC_LAT);
                    end
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    if (head.rd != 5'd0) begin
                        state_d  = S_RESP;
                        res_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        pop     = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (x_rready_i) begin
                    state_d = S_IDLE;
                    pop     = 1'b1;
                end
            end
            S_MREQ: begin
                if (xmem_ready_i) state_d = S_MRESP;
            end
            S_MRESP: begin
                if (xmem_rvalid_i) begin
                    state_d = S_IDLE;
                    pop     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_rwaddr_o      <= '0;
            x_rdata_o       <= '0;
            xmem_addr_o     <= '0;
            xmem_wdata_o    <= '0;
            xmem_req_type_o <= MEM_READ;
        end else begin
            if (res_load) begin
                x_rwaddr_o <= head.rd;
                x_rdata_o  <= alu_op(head.op, head.rs1, head.rs2);
            end
            if (mreq_load) begin
                xmem_addr_o     <= head.rs1;
                xmem_wdata_o    <= head.rs2;
                xmem_req_type_o <= head.op[0] ? MEM_WRITE : MEM_READ;
            end
        end
    end

    assign x_rvalid_o              = (state_q == S_RESP);
    assign xmem_valid_o            = (state_q == S_MREQ);
    assign xmem_rready_o           = (state_q == S_MRESP);
    assign xmem_endoftransaction_o = xmem_valid_o;

endmodule

// File: tb/tb_cv32e40p_x_acc_resp.sv
// Bench for cv32e40p_x_acc_resp: directed protocol scenarios followed by a
// randomized run scored against an in-order reference model.
module tb_cv32e40p_x_acc_resp;
    import cv32e40p_x_acc_pkg::*;

    localparam logic [6:0] OPC_COMP = 7'b0001011;
    localparam logic [6:0] OPC_MEM  = 7'b0101011;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              x_valid_i;
    logic              x_ready_o;
    logic [31:0]       x_instr_i;
    logic [1:0][31:0]  x_rs_i;
    logic [1:0]        x_rs_valid_i;
    logic              x_rd_clean_i;
    logic              x_accept_o;
    logic              x_is_mem_op_o;
    logic              x_writeback_o;
    logic              x_rvalid_o;
    logic              x_rready_i;
    logic [4:0]        x_rwaddr_o;
    logic [31:0]       x_rdata_o;
    logic              xmem_valid_o;
    logic              xmem_ready_i;
    mem_req_type_e     xmem_req_type_o;
    logic [31:0]       xmem_addr_o;
    logic [31:0]       xmem_wdata_o;
    logic              xmem_endoftransaction_o;
    logic              xmem_rvalid_i;
    logic              xmem_rready_o;

    int checks = 0;
    int failures = 0;

    cv32e40p_x_acc_resp #(.DEPTH(4), .EXEC_LAT(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_instr_i(x_instr_i),
        .x_rs_i(x_rs_i), .x_rs_valid_i(x_rs_valid_i), .x_rd_clean_i(x_rd_clean_i),
        .x_accept_o(x_accept_o), .x_is_mem_op_o(x_is_mem_op_o), .x_writeback_o(x_writeback_o),
        .x_rvalid_o(x_rvalid_o), .x_rready_i(x_rready_i), .x_rwaddr_o(x_rwaddr_o),
        .x_rdata_o(x_rdata_o), .xmem_valid_o(xmem_valid_o), .xmem_ready_i(xmem_ready_i),
        .xmem_req_type_o(xmem_req_type_o), .xmem_addr_o(xmem_addr_o),
        .xmem_wdata_o(xmem_wdata_o), .xmem_endoftransaction_o(xmem_endoftransaction_o),
        .xmem_rvalid_i(xmem_rvalid_i), .xmem_rready_o(xmem_rready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, op};
    endfunction

    // Reference semantics of the offload ISA subset
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        x_valid_i = 1'b1; x_instr_i = ins; x_rs_i[0] = a; x_rs_i[1] = b;
        #1;
        while (!x_ready_o && n < 50) begin tick(); #1; n++; end
        chk1("send_ready", x_ready_o, 1'b1);
        tick();
        x_valid_i = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [4:0] rd, input logic [31:0] d);
        int n = 0;
        x_rready_i = 1'b0;
        while (!x_rvalid_o && n < 30) begin tick(); n++; end
        chk1({tag, "_rvalid"}, x_rvalid_o, 1'b1);
        chk32({tag, "_rwaddr"}, 32'(x_rwaddr_o), 32'(rd));
        chk32({tag, "_rdata"}, x_rdata_o, d);
        x_rready_i = 1'b1;
        tick();
        x_rready_i = 1'b0;
    endtask

    typedef struct { logic [4:0] rd; logic [31:0] d; } res_t;
    typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } mreq_t;
    res_t  exp_res[$];
    mreq_t exp_mem[$];
    logic  mon_en = 1'b0;
    logic  hold_r = 1'b0;
    logic  hold_m = 1'b0;
    logic [4:0]  prev_wa;
    logic [31:0] prev_d;
    logic [31:0] prev_addr;

    // Scoreboard for the randomized phase
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (hold_r) begin
                chk1("hold_rvalid", x_rvalid_o, 1'b1);
                chk32("hold_rdata", x_rdata_o, prev_d);
                chk32("hold_rwaddr", 32'(x_rwaddr_o), 32'(prev_wa));
            end
            if (hold_m) begin
                chk1("hold_xmem_valid", xmem_valid_o, 1'b1);
                chk32("hold_xmem_addr", xmem_addr_o, prev_addr);
            end
            if (x_rvalid_o && x_rready_i) begin
                if (exp_res.size() == 0) begin
                    chk1("rnd_unexpected_result", x_rvalid_o, 1'b0);
                end else begin
                    res_t e;
                    e = exp_res.pop_front();
                    chk32("rnd_rwaddr", 32'(x_rwaddr_o), 32'(e.rd));
                    chk32("rnd_rdata", x_rdata_o, e.d);
                end
            end
            if (xmem_valid_o && xmem_ready_i) begin
                if (exp_mem.size() == 0) begin
                    chk1("rnd_unexpected_xmem", xmem_valid_o, 1'b0);
                end else begin
                    mreq_t m;
                    m = exp_mem.pop_front();
                    chk1("rnd_xmem_type", xmem_req_type_o == MEM_WRITE, m.wr);
                    chk32("rnd_xmem_addr", xmem_addr_o, m.addr);
                    chk32("rnd_xmem_wdata", xmem_wdata_o, m.wdata);
                end
            end
            hold_r    <= x_rvalid_o && !x_rready_i;
            hold_m    <= xmem_valid_o && !xmem_ready_i;
            prev_wa   <= x_rwaddr_o;
            prev_d    <= x_rdata_o;
            prev_addr <= xmem_addr_o;
        end
    end

    initial begin
        rst_i = 1'b1; x_valid_i = 1'b0; x_instr_i = '0; x_rs_i = '0;
        x_rs_valid_i = 2'b11; x_rd_clean_i = 1'b1; x_rready_i = 1'b0;
        xmem_ready_i = 1'b0; xmem_rvalid_i = 1'b0;
        tick(); tick();
        chk1("rst_rvalid", x_rvalid_o, 1'b0);
        chk1("rst_xmem_valid", xmem_valid_o, 1'b0);
        chk1("rst_xmem_rready", xmem_rready_o, 1'b0);
        chk32("rst_rdata", x_rdata_o, 32'd0);
        chk32("rst_rwaddr", 32'(x_rwaddr_o), 32'd0);
        chk32("rst_xmem_addr", xmem_addr_o, 32'd0);
        chk32("rst_xmem_wdata", xmem_wdata_o, 32'd0);
        rst_i = 1'b0;
        tick();
        x_instr_i = mk(OPC_COMP, 3'd0, 5'd5);
        #1;
        chk1("post_rst_ready", x_ready_o, 1'b1);

        // ADD rd=5: exact latency and hold-under-backpressure
        x_valid_i = 1'b1; x_rs_i[0] = 32'd3; x_rs_i[1] = 32'd4;
        #1;
        chk1("add_accept", x_accept_o, 1'b1);
        chk1("add_writeback", x_writeback_o, 1'b1);
        chk1("add_is_mem", x_is_mem_op_o, 1'b0);
        chk1("add_ready", x_ready_o, 1'b1);
        tick(); x_valid_i = 1'b0;
        chk1("add_c1_rvalid", x_rvalid_o, 1'b0);
        tick(); chk1("add_c2_rvalid", x_rvalid_o, 1'b0);
        tick(); chk1("add_c3_rvalid", x_rvalid_o, 1'b0);
        tick();
        for (int c = 0; c < 3; c++) begin
            chk1("add_hold_rvalid", x_rvalid_o, 1'b1);
            chk32("add_hold_rwaddr", 32'(x_rwaddr_o), 32'd5);
            chk32("add_hold_rdata", x_rdata_o, 32'd7);
            tick();
        end
        chk1("add_c7_rvalid", x_rvalid_o, 1'b1);
        x_rready_i = 1'b1;
        tick(); x_rready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk1("add_after_rvalid", x_rvalid_o, 1'b0);
            tick();
        end

        // Illegal opcode is consumed without effect
        x_valid_i = 1'b1; x_instr_i = mk(7'b0110011, 3'd0, 5'd3);
        #1;
        chk1("rej_ready", x_ready_o, 1'b1);
        chk1("rej_accept", x_accept_o, 1'b0);
        chk1("rej_writeback", x_writeback_o, 1'b0);
        tick(); x_valid_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk1("rej_no_activity", x_rvalid_o || xmem_valid_o, 1'b0);
            tick();
        end

        // Fill the queue; the fifth legal request must stall
        for (int i = 1; i <= 4; i++) send(mk(OPC_COMP, 3'd0, 5'(i)), 32'(10 * i), 32'(i));
        x_instr_i = mk(OPC_COMP, 3'd0, 5'd9);
        #1;
        chk1("full_ready", x_ready_o, 1'b0);
        expect_result("full_r1", 5'd1, 32'd11);
        chk1("full_ready_after_pop", x_ready_o, 1'b1);
        expect_result("full_r2", 5'd2, 32'd22);
        expect_result("full_r3", 5'd3, 32'd33);
        expect_result("full_r4", 5'd4, 32'd44);

        // Store with request and response backpressure
        x_instr_i = mk(OPC_MEM, 3'd1, 5'd0);
        #1;
        chk1("st_accept", x_accept_o, 1'b1);
        chk1("st_is_mem", x_is_mem_op_o, 1'b1);
        chk1("st_writeback", x_writeback_o, 1'b0);
        send(mk(OPC_MEM, 3'd1, 5'd0), 32'h100, 32'hAB);
        begin
            int n = 0;
            while (!xmem_valid_o && n < 20) begin tick(); n++; end
        end
        for (int c = 0; c < 3; c++) begin
            chk1("st_xmem_valid", xmem_valid_o, 1'b1);
            chk1("st_type_write", xmem_req_type_o == MEM_WRITE, 1'b1);
            chk32("st_addr", xmem_addr_o, 32'h100);
            chk32("st_wdata", xmem_wdata_o, 32'hAB);
            chk1("st_eot", xmem_endoftransaction_o, 1'b1);
            tick();
        end
        xmem_ready_i = 1'b1;
        tick(); xmem_ready_i = 1'b0;
        chk1("st_mresp_valid_low", xmem_valid_o, 1'b0);
        for (int c = 0; c < 2; c++) begin
            chk1("st_rready", xmem_rready_o, 1'b1);
            chk1("st_no_rvalid", x_rvalid_o, 1'b0);
            tick();
        end
        xmem_rvalid_i = 1'b1;
        tick(); xmem_rvalid_i = 1'b0;
        chk1("st_retired", xmem_rready_o, 1'b0);
        chk1("st_no_rvalid_end", x_rvalid_o, 1'b0);

        // rd=0 SUB retires silently; XOR result follows in order
        x_instr_i = mk(OPC_COMP, 3'd1, 5'd0);
        #1;
        chk1("sub_writeback", x_writeback_o, 1'b0);
        chk1("sub_accept", x_accept_o, 1'b1);
        send(mk(OPC_COMP, 3'd1, 5'd0), 32'd1, 32'd2);
        send(mk(OPC_COMP, 3'd2, 5'd7), 32'hF0, 32'hFF);
        expect_result("xor", 5'd7, 32'h0F);

        // Reset while a result is pending with more entries queued
        send(mk(OPC_COMP, 3'd0, 5'd1), 32'd1, 32'd1);
        send(mk(OPC_COMP, 3'd3, 5'd2), 32'hFF, 32'h0F);
        send(mk(OPC_COMP, 3'd0, 5'd3), 32'd2, 32'd2);
        begin
            int n = 0;
            while (!x_rvalid_o && n < 20) begin tick(); n++; end
        end
        chk1("rr_rvalid_before", x_rvalid_o, 1'b1);
        rst_i = 1'b1;
        #1;
        chk1("rr_rvalid_now", x_rvalid_o, 1'b0);
        chk32("rr_rdata", x_rdata_o, 32'd0);
        chk32("rr_rwaddr", 32'(x_rwaddr_o), 32'd0);
        tick(); rst_i = 1'b0;
        x_instr_i = mk(OPC_COMP, 3'd0, 5'd9);
        #1;
        chk1("rr_ready", x_ready_o, 1'b1);
        for (int c = 0; c < 6; c++) begin
            chk1("rr_queue_empty", x_rvalid_o || xmem_valid_o, 1'b0);
            tick();
        end
        send(mk(OPC_COMP, 3'd0, 5'd9), 32'd5, 32'd6);
        expect_result("rr_add", 5'd9, 32'd11);

        // Randomized traffic against the in-order model
        mon_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            logic [6:0]  op;
            logic [2:0]  f3;
            logic [4:0]  rd;
            logic        acc, is_mem, wb, upper;
            r  = $urandom();
            case ($urandom_range(0, 4))
                0, 1:    op = OPC_COMP;
                2, 3:    op = OPC_MEM;
                default: op = 7'($urandom());
            endcase
            f3 = 3'($urandom_range(0, 7));
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            x_instr_i    = {r[31:15], f3, rd, op};
            x_rs_i[0]    = $urandom();
            x_rs_i[1]    = $urandom();
            x_valid_i    = 1'($urandom_range(0, 1));
            x_rs_valid_i = ($urandom_range(0, 7) == 0) ? 2'($urandom()) : 2'b11;
            x_rd_clean_i = ($urandom_range(0, 3) != 0);
            x_rready_i   = ($urandom_range(0, 2) != 0);
            xmem_ready_i = ($urandom_range(0, 2) != 0);
            xmem_rvalid_i = 1'($urandom_range(0, 1));
            #1;
            is_mem = (op == OPC_MEM) && (f3 < 3'd2);
            acc    = is_mem || ((op == OPC_COMP) && (f3 < 3'd4));
            wb     = acc && !is_mem && (rd != 5'd0);
            upper  = (x_rs_valid_i == 2'b11) && (x_rd_clean_i || !wb);
            chk1("rnd_accept", x_accept_o, acc);
            chk1("rnd_is_mem", x_is_mem_op_o, is_mem);
            chk1("rnd_writeback", x_writeback_o, wb);
            if (!acc) chk1("rnd_ready_reject", x_ready_o, 1'b1);
            else if (!upper) chk1("rnd_ready_blocked", x_ready_o, 1'b0);
            if (x_valid_i && x_ready_o && acc) begin
                if (is_mem) exp_mem.push_back('{wr: f3[0], addr: x_rs_i[0], wdata: x_rs_i[1]});
                else if (rd != 5'd0) exp_res.push_back('{rd: rd, d: ref_alu(f3, x_rs_i[0], x_rs_i[1])});
            end
            tick();
        end
        x_valid_i = 1'b0; x_rready_i = 1'b1; xmem_ready_i = 1'b1; xmem_rvalid_i = 1'b1;
        begin
            int n = 0;
            while ((exp_res.size() != 0 || exp_mem.size() != 0) && n < 300) begin tick(); n++; end
        end
        tick(); tick();
        mon_en = 1'b0;
        chk32("drain_results", 32'(exp_res.size()), 32'd0);
        chk32("drain_xmem", 32'(exp_mem.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
